// File: rtl/sim_axi_mem_pkg.sv
// Shared widths, AXI encodings and FSM state types for the simulation AXI4 memory.
package sim_axi_mem_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 31;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } w_state_t;

    typedef enum logic [0:0] {
        RIdle,
        RData
    } r_state_t;

endpackage

// File: rtl/sim_axi_mem_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module sim_axi_mem_addr_gen
    import sim_axi_mem_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;

    // Select the next address by burst type; the reserved encoding behaves as INCR.
    always_comb begin
        step      = ADDR_W'(1) << size_i;
        // Legal WRAP lengths make (len+1)*step a power of two, so total-1 is a mask.
        wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        incr_addr = addr_i + step;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/sim_axi_mem.sv
// Simulation AXI4 slave memory: independent read and write engines, one burst in flight each.
module sim_axi_mem
    import sim_axi_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 2**20,
    parameter string       INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic              io_axi4_0_awready,
    input  logic              io_axi4_0_awvalid,
    input  logic [ID_W-1:0]   io_axi4_0_awid,
    input  logic [ADDR_W-1:0] io_axi4_0_awaddr,
    input  logic [7:0]        io_axi4_0_awlen,
    input  logic [2:0]        io_axi4_0_awsize,
    input  logic [1:0]        io_axi4_0_awburst,
    output logic              io_axi4_0_wready,
    input  logic              io_axi4_0_wvalid,
    input  logic [DATA_W-1:0] io_axi4_0_wdata,
    input  logic [STRB_W-1:0] io_axi4_0_wstrb,
    input  logic              io_axi4_0_wlast,
    input  logic              io_axi4_0_bready,
    output logic              io_axi4_0_bvalid,
    output logic [ID_W-1:0]   io_axi4_0_bid,
    output logic [1:0]        io_axi4_0_bresp,
    output logic              io_axi4_0_arready,
    input  logic              io_axi4_0_arvalid,
    input  logic [ID_W-1:0]   io_axi4_0_arid,
    input  logic [ADDR_W-1:0] io_axi4_0_araddr,
    input  logic [7:0]        io_axi4_0_arlen,
    input  logic [2:0]        io_axi4_0_arsize,
    input  logic [1:0]        io_axi4_0_arburst,
    input  logic              io_axi4_0_rready,
    output logic              io_axi4_0_rvalid,
    output logic [ID_W-1:0]   io_axi4_0_rid,
    output logic [DATA_W-1:0] io_axi4_0_rdata,
    output logic [1:0]        io_axi4_0_rresp,
    output logic              io_axi4_0_rlast
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_next;
    logic [7:0]        w_len_q;
    logic [2:0]        w_size_q;
    logic [1:0]        w_burst_q;
    logic              aw_fire, w_fire;

    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_next;
    logic [7:0]        r_len_q, r_beat_q, r_beat_d;
    logic [2:0]        r_size_q;
    logic [1:0]        r_burst_q;
    logic              ar_fire;

    logic [IDX_W-1:0]  w_idx, r_idx;

    // Upper address bits alias; only the word-index slice selects storage.
    assign w_idx = w_addr_q[3 +: IDX_W];
    assign r_idx = r_addr_q[3 +: IDX_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr_q, r_addr_q};

    sim_axi_mem_addr_gen u_w_addr_gen (
        .addr_i      (w_addr_q),
        .size_i      (w_size_q),
        .len_i       (w_len_q),
        .burst_i     (w_burst_q),
        .next_addr_o (w_next)
    );

    sim_axi_mem_addr_gen u_r_addr_gen (
        .addr_i      (r_addr_q),
        .size_i      (r_size_q),
        .len_i       (r_len_q),
        .burst_i     (r_burst_q),
        .next_addr_o (r_next)
    );

    assign aw_fire = io_axi4_0_awvalid & io_axi4_0_awready;
    assign w_fire  = io_axi4_0_wvalid & io_axi4_0_wready;
    assign ar_fire = io_axi4_0_arvalid & io_axi4_0_arready;

    // Write engine next state; handshake outputs are held low while in reset.
    always_comb begin
        w_state_d         = w_state_q;
        w_addr_d          = w_addr_q;
        io_axi4_0_awready = 1'b0;
        io_axi4_0_wready  = 1'b0;
        io_axi4_0_bvalid  = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                io_axi4_0_awready = rst_n;
                if (aw_fire) begin
                    w_addr_d  = io_axi4_0_awaddr;
                    w_state_d = WData;
                end
            end
            WData: begin
                io_axi4_0_wready = rst_n;
                if (w_fire) begin
                    w_addr_d = w_next;
                    // wlast alone ends the burst; awlen only shapes WRAP.
                    if (io_axi4_0_wlast) w_state_d = WResp;
                end
            end
            WResp: begin
                io_axi4_0_bvalid = rst_n;
                if (io_axi4_0_bready && rst_n) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    assign io_axi4_0_bid   = w_id_q;
    assign io_axi4_0_bresp = RESP_OKAY;

    // Write engine state and latched AW fields.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            if (aw_fire) begin
                w_id_q    <= io_axi4_0_awid;
                w_len_q   <= io_axi4_0_awlen;
                w_size_q  <= io_axi4_0_awsize;
                w_burst_q <= io_axi4_0_awburst;
            end
        end
    end

    // Byte-lane writes under wstrb; storage is never reset.
    always_ff @(posedge clock) begin
        if (w_fire) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (io_axi4_0_wstrb[i]) mem[w_idx][8*i +: 8] <= io_axi4_0_wdata[8*i +: 8];
            end
        end
    end

    // Read engine next state; handshake outputs are held low while in reset.
    always_comb begin
        r_state_d         = r_state_q;
        r_addr_d          = r_addr_q;
        r_beat_d          = r_beat_q;
        io_axi4_0_arready = 1'b0;
        io_axi4_0_rvalid  = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                io_axi4_0_arready = rst_n;
                if (ar_fire) begin
                    r_addr_d  = io_axi4_0_araddr;
                    r_beat_d  = '0;
                    r_state_d = RData;
                end
            end
            RData: begin
                io_axi4_0_rvalid = rst_n;
                if (io_axi4_0_rready && rst_n) begin
                    r_addr_d = r_next;
                    r_beat_d = r_beat_q + 8'd1;
                    if (io_axi4_0_rlast) r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign io_axi4_0_rid   = r_id_q;
    assign io_axi4_0_rresp = RESP_OKAY;
    assign io_axi4_0_rlast = (r_state_q == RData) && (r_beat_q == r_len_q);
    // Combinational read: a same-cycle write to this word lands after the edge.
    assign io_axi4_0_rdata = (r_state_q == RData) ? mem[r_idx] : '0;

    // Read engine state and latched AR fields.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_beat_q  <= r_beat_d;
            if (ar_fire) begin
                r_id_q    <= io_axi4_0_arid;
                r_len_q   <= io_axi4_0_arlen;
                r_size_q  <= io_axi4_0_arsize;
                r_burst_q <= io_axi4_0_arburst;
            end
        end
    end

endmodule

// File: tb/tb_sim_axi_mem.sv
// Randomised scoreboard bench for sim_axi_mem with a byte-level reference memory.
module tb_sim_axi_mem;

    localparam int MW = 4096;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clock = ~clock;

    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic [3:0]  awid, bid, arid, rid;
    logic [30:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arready, arvalid, rready, rvalid, rlast;

    logic bp_rand, rnd_r, rnd_b, rready_ctl, bready_ctl;
    assign rready = bp_rand ? rnd_r : rready_ctl;
    assign bready = bp_rand ? rnd_b : bready_ctl;

    sim_axi_mem #(.MEM_WORDS(MW), .INIT_FILE("")) dut (
        .clock(clock), .rst_n(rst_n),
        .io_axi4_0_awready(awready), .io_axi4_0_awvalid(awvalid), .io_axi4_0_awid(awid),
        .io_axi4_0_awaddr(awaddr), .io_axi4_0_awlen(awlen), .io_axi4_0_awsize(awsize),
        .io_axi4_0_awburst(awburst),
        .io_axi4_0_wready(wready), .io_axi4_0_wvalid(wvalid), .io_axi4_0_wdata(wdata),
        .io_axi4_0_wstrb(wstrb), .io_axi4_0_wlast(wlast),
        .io_axi4_0_bready(bready), .io_axi4_0_bvalid(bvalid), .io_axi4_0_bid(bid),
        .io_axi4_0_bresp(bresp),
        .io_axi4_0_arready(arready), .io_axi4_0_arvalid(arvalid), .io_axi4_0_arid(arid),
        .io_axi4_0_araddr(araddr), .io_axi4_0_arlen(arlen), .io_axi4_0_arsize(arsize),
        .io_axi4_0_arburst(arburst),
        .io_axi4_0_rready(rready), .io_axi4_0_rvalid(rvalid), .io_axi4_0_rid(rid),
        .io_axi4_0_rdata(rdata), .io_axi4_0_rresp(rresp), .io_axi4_0_rlast(rlast)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
    } rexp_t;

    rexp_t       r_q[$];
    logic [3:0]  b_q[$];
    logic [63:0] model [MW];
    int          total = 0;
    int          bad = 0;
    int          r_popped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: no DUT response within bound at %0t", name, $time);
    endtask

    // Byte address of beat k from AXI burst rules.
    function automatic logic [30:0] beat_addr(input logic [30:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int k);
        longint step, tot, base, a;
        step = longint'(1) << size;
        a    = longint'(addr);
        if (burst == 2'b00) return addr;
        if (burst == 2'b10) begin
            tot  = (longint'(len) + 1) * step;
            base = (a / tot) * tot;
            return 31'(base + (a - base + longint'(k) * step) % tot);
        end
        return 31'((a + longint'(k) * step) % (longint'(1) << 31));
    endfunction

    function automatic int widx(input logic [30:0] a);
        return int'(a >> 3) % MW;
    endfunction

    task automatic monitor();
        logic        stalled = 1'b0;
        logic [63:0] s_data = '0;
        logic        s_last = 1'b0;
        rexp_t       e;
        logic [3:0]  eb;
        forever begin
            @(negedge clock);
            if (stalled && rst_n) begin
                check("r_hold_valid", 64'(rvalid), 64'd1);
                check("r_hold_data", rdata, s_data);
                check("r_hold_last", 64'(rlast), 64'(s_last));
            end
            stalled = rst_n && rvalid && !rready;
            s_data  = rdata;
            s_last  = rlast;
            if (rvalid && rready) begin
                if (r_q.size() == 0) flag_fail("r_unexpected_beat");
                else begin
                    e = r_q.pop_front();
                    check("rid", 64'(rid), 64'(e.id));
                    check("rdata", rdata, e.data);
                    check("rlast", 64'(rlast), 64'(e.last));
                    check("rresp", 64'(rresp), 64'd0);
                    r_popped++;
                end
            end
            if (bvalid && bready) begin
                if (b_q.size() == 0) flag_fail("b_unexpected");
                else begin
                    eb = b_q.pop_front();
                    check("bid", 64'(bid), 64'(eb));
                    check("bresp", 64'(bresp), 64'd0);
                end
            end
        end
    endtask

    task automatic bp_gen();
        forever begin
            @(posedge clock);
            #1;
            rnd_r = ($urandom % 4) != 0;
            rnd_b = ($urandom % 4) != 0;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [63:0] data[$], input logic [7:0] strb[$]);
        int n, idx;
        for (int k = 0; k <= int'(len); k++) begin
            idx = widx(beat_addr(addr, len, size, burst, k));
            for (int i = 0; i < 8; i++)
                if (strb[k][i]) model[idx][8*i +: 8] = data[k][8*i +: 8];
        end
        b_q.push_back(id);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        n = 0;
        do begin @(negedge clock); n++; end while (!awready && n < 300);
        if (!awready) flag_fail("aw_timeout");
        @(posedge clock); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wvalid = 1'b1; wdata = data[k]; wstrb = strb[k]; wlast = (k == int'(len));
            n = 0;
            do begin @(negedge clock); n++; end while (!wready && n < 300);
            if (!wready) flag_fail("w_timeout");
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_wlast", 64'(bvalid), 64'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int    n;
        rexp_t e;
        for (int k = 0; k <= int'(len); k++) begin
            e.id   = id;
            e.data = model[widx(beat_addr(addr, len, size, burst, k))];
            e.last = (k == int'(len));
            r_q.push_back(e);
        end
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        n = 0;
        do begin @(negedge clock); n++; end while (!arready && n < 300);
        if (!arready) flag_fail("ar_timeout");
        @(posedge clock); #1;
        arvalid = 1'b0;
        check("rvalid_after_ar", 64'(rvalid), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (r_q.size() != 0 || b_q.size() != 0) begin
            flag_fail("drain_timeout");
            r_q.delete();
            b_q.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic write1(input logic [3:0] id, input logic [30:0] addr, input logic [63:0] d,
                          input logic [7:0] s);
        logic [63:0] dq[$];
        logic [7:0]  sq[$];
        dq.push_back(d);
        sq.push_back(s);
        do_write(id, addr, 8'd0, 3'd3, 2'b01, dq, sq);
    endtask

    task automatic rand_params(input int base_word, output logic [30:0] addr, output logic [7:0] len,
                               output logic [2:0] size, output logic [1:0] burst);
        int step;
        size  = (($urandom % 4) == 0) ? 3'($urandom % 3) : 3'd3;
        burst = 2'($urandom % 4);
        step  = 1 << size;
        if (burst == 2'b10) len = 8'((1 << ($urandom % 4)) - 1);
        else len = 8'($urandom % 8);
        addr = 31'(base_word * 8 + int'($urandom % 192) * 8 + (int'($urandom % 8) & ~(step - 1)));
    endtask

    initial begin
        logic [63:0] dq[$];
        logic [7:0]  sq[$];
        logic [30:0] wa, ra;
        logic [7:0]  wl, rl;
        logic [2:0]  ws, rs;
        logic [1:0]  wb, rb;
        int          base, n;

        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        bp_rand = 0; rnd_r = 1; rnd_b = 1; rready_ctl = 1; bready_ctl = 1;
        for (int i = 0; i < MW; i++) model[i] = '0;

        fork
            monitor();
            bp_gen();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset: every handshake output low.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        check("idle_awready", 64'(awready), 64'd1);
        check("idle_arready", 64'(arready), 64'd1);
        check("idle_wready", 64'(wready), 64'd0);
        check("idle_outputs_known", 64'($isunknown({rdata, rid, bid, rlast, bresp, rresp})), 64'd0);
        @(posedge clock); #1;

        // Fill words 0..511 with two 256-beat INCR bursts.
        for (int b = 0; b < 2; b++) begin
            dq.delete(); sq.delete();
            for (int k = 0; k < 256; k++) begin
                dq.push_back({$urandom, $urandom});
                sq.push_back(8'hFF);
            end
            do_write(4'(b), 31'(b * 2048), 8'd255, 3'd3, 2'b01, dq, sq);
            wait_idle();
        end

        // Single write then read back.
        write1(4'h5, 31'h100, 64'h1122334455667788, 8'hFF);
        wait_idle();
        do_read(4'h9, 31'h100, 8'd0, 3'd3, 2'b01);
        wait_idle();

        // Byte strobes over an all-ones word.
        write1(4'h1, 31'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        write1(4'h2, 31'h40, 64'h0, 8'h0F);
        wait_idle();
        do_read(4'h4, 31'h40, 8'd0, 3'd3, 2'b01);
        wait_idle();

        // INCR burst 1..4, then INCR read and WRAP read of the same lines.
        dq.delete(); sq.delete();
        for (int k = 0; k < 4; k++) begin dq.push_back(64'(k + 1)); sq.push_back(8'hFF); end
        do_write(4'h7, 31'h200, 8'd3, 3'd3, 2'b01, dq, sq);
        wait_idle();
        do_read(4'h3, 31'h200, 8'd3, 3'd3, 2'b01);
        wait_idle();
        do_read(4'hB, 31'h218, 8'd3, 3'd3, 2'b10);
        wait_idle();

        // Aliasing: one MW-word period above 0x100.
        do_read(4'hA, 31'(32'h100 + MW * 8), 8'd0, 3'd3, 2'b01);
        wait_idle();

        // R backpressure: stall 5 cycles after the first beat.
        base = r_popped;
        do_read(4'h3, 31'h200, 8'd3, 3'd3, 2'b01);
        n = 0;
        while (r_popped < base + 1 && n < 200) begin @(negedge clock); #1; n++; end
        @(posedge clock); #1;
        rready_ctl = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        rready_ctl = 1'b1;
        wait_idle();

        // B backpressure: bvalid held for 3 cycles.
        bready_ctl = 1'b0;
        write1(4'hC, 31'h300, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        repeat (3) begin
            @(negedge clock);
            check("b_held", 64'(bvalid), 64'd1);
        end
        @(posedge clock); #1;
        bready_ctl = 1'b1;
        wait_idle();

        // Reset while the read engine is presenting beat 2.
        base = r_popped;
        do_read(4'h6, 31'h0, 8'd7, 3'd3, 2'b01);
        n = 0;
        while (r_popped < base + 2 && n < 200) begin @(negedge clock); #1; n++; end
        @(posedge clock); #1;
        rst_n = 1'b0;
        @(negedge clock);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_arready", 64'(arready), 64'd0);
        check("mid_rst_awready", 64'(awready), 64'd0);
        check("mid_rst_wready", 64'(wready), 64'd0);
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        r_q.delete();
        @(posedge clock); @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        check("post_rst_arready", 64'(arready), 64'd1);
        check("post_rst_awready", 64'(awready), 64'd1);
        check("post_rst_rvalid", 64'(rvalid), 64'd0);
        @(posedge clock); #1;
        do_read(4'h6, 31'h0, 8'd7, 3'd3, 2'b01);
        wait_idle();

        // Random concurrent traffic: write and read in disjoint halves.
        bp_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            rand_params((it % 2) ? 256 : 0, wa, wl, ws, wb);
            rand_params((it % 2) ? 0 : 256, ra, rl, rs, rb);
            dq.delete(); sq.delete();
            for (int k = 0; k <= int'(wl); k++) begin
                dq.push_back({$urandom, $urandom});
                sq.push_back(8'($urandom));
            end
            fork
                do_write(4'($urandom), wa, wl, ws, wb, dq, sq);
                do_read(4'($urandom), ra, rl, rs, rb);
            join
            wait_idle();
        end
        bp_rand = 1'b0;

        // Full readback of both halves.
        do_read(4'h1, 31'h0, 8'd255, 3'd3, 2'b01);
        wait_idle();
        do_read(4'h2, 31'h800, 8'd255, 3'd3, 2'b01);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
